// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the CNN result argmax block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

   localparam int CNN_DATA_WIDTH  = 32;
   localparam int CNN_NUM_CLASSES = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/cnn_score_bank.sv
// Score register file: one write port, one registered read port.
// Latency: read data appears 1 cycle after rd_idx; reads see pre-write contents.
// Backpressure: none, accepts a write and serves a read every cycle.
module cnn_score_bank #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int NUM_CLASSES = 10,
   localparam int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_WIDTH-1:0]  wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   // Width-matched class count so out-of-range read indices can be detected.
   localparam logic [IDX_WIDTH:0] NUM_C = (IDX_WIDTH+1)'(NUM_CLASSES);

   logic [DATA_WIDTH-1:0] mem [NUM_CLASSES];

   // Storage update and registered read; unused index space reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            mem[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= wr_data;
         end
         if ({1'b0, rd_idx} < NUM_C) begin
            rd_data <= mem[rd_idx];
         end else begin
            rd_data <= '0;
         end
      end
   end

endmodule

// File: rtl/cnn_result_argmax.sv
// Collects NUM_CLASSES signed scores, tracks running argmax, presents class/score.
// Latency: result valid 1 cycle after the last score is accepted.
// Backpressure: s_ready only in COLLECT; result held until res_ready.
module cnn_result_argmax
   import cnn_pkg::*;
#(
   parameter  int DATA_WIDTH  = CNN_DATA_WIDTH,
   parameter  int NUM_CLASSES = CNN_NUM_CLASSES,
   localparam int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic [IDX_WIDTH-1:0]  rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [IDX_WIDTH-1:0]  res_class,
   output logic [DATA_WIDTH-1:0] res_score,
   output logic                  busy
);

   localparam logic [IDX_WIDTH:0] LAST = (IDX_WIDTH+1)'(NUM_CLASSES - 1);
   localparam logic [IDX_WIDTH:0] ONE  = (IDX_WIDTH+1)'(1);

   state_t                        state;
   logic [IDX_WIDTH:0]            count;
   logic signed [DATA_WIDTH-1:0]  max_q;
   logic [IDX_WIDTH-1:0]          idx_q;
   logic signed [DATA_WIDTH-1:0]  score_s;
   logic                          accept;
   logic                          take;
   logic signed [DATA_WIDTH-1:0]  next_max;
   logic [IDX_WIDTH-1:0]          next_idx;

   assign s_ready   = (state == COLLECT);
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign score_s   = s_data;

   // A score arriving with a restart pulse is dropped so the new run starts clean.
   assign accept = s_valid & s_ready & ~start;

   // First score seeds the max; later ones win only when strictly greater.
   always_comb begin
      take     = (count == '0) || (score_s > max_q);
      next_max = take ? score_s : max_q;
      next_idx = take ? count[IDX_WIDTH-1:0] : idx_q;
   end

   // Collection FSM, running argmax and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         res_class <= '0;
         res_score <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COLLECT;
                  count <= '0;
               end
            end
            COLLECT: begin
               if (start) begin
                  count <= '0;
               end else if (accept) begin
                  count <= count + ONE;
                  max_q <= next_max;
                  idx_q <= next_idx;
                  if (count == LAST) begin
                     state     <= DONE;
                     res_class <= next_idx;
                     res_score <= next_max;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   cnn_score_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_CLASSES (NUM_CLASSES)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_idx  (count[IDX_WIDTH-1:0]),
      .wr_data (s_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed bench for cnn_result_argmax: table-driven vectors plus corner sequences.
// Latency: checks result valid exactly 1 cycle after the last accepted score.
// Backpressure: exercises gapped s_valid and delayed res_ready.
module tb_cnn_result_argmax;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: 10 classes x 32 bits
   logic        rst, start, s_valid, s_ready, res_valid, res_ready, busy;
   logic [31:0] s_data, rd_data, res_score;
   logic [3:0]  rd_idx, res_class;

   // sweep instance: 2 classes x 16 bits
   logic        start_a, s_valid_a, s_ready_a, res_valid_a, res_ready_a, busy_a;
   logic [15:0] s_data_a, rd_data_a, res_score_a;
   logic [0:0]  rd_idx_a, res_class_a;

   // sweep instance: 256 classes x 16 bits
   logic        start_b, s_valid_b, s_ready_b, res_valid_b, res_ready_b, busy_b;
   logic [15:0] s_data_b, rd_data_b, res_score_b;
   logic [7:0]  rd_idx_b, res_class_b;

   cnn_result_argmax #(.DATA_WIDTH(32), .NUM_CLASSES(10)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .rd_idx(rd_idx), .rd_data(rd_data), .res_valid(res_valid),
      .res_ready(res_ready), .res_class(res_class), .res_score(res_score), .busy(busy));

   cnn_result_argmax #(.DATA_WIDTH(16), .NUM_CLASSES(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid_a), .s_data(s_data_a),
      .s_ready(s_ready_a), .rd_idx(rd_idx_a), .rd_data(rd_data_a), .res_valid(res_valid_a),
      .res_ready(res_ready_a), .res_class(res_class_a), .res_score(res_score_a), .busy(busy_a));

   cnn_result_argmax #(.DATA_WIDTH(16), .NUM_CLASSES(256)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_data(s_data_b),
      .s_ready(s_ready_b), .rd_idx(rd_idx_b), .rd_data(rd_data_b), .res_valid(res_valid_b),
      .res_ready(res_ready_b), .res_class(res_class_b), .res_score(res_score_b), .busy(busy_b));

   typedef struct {
      logic [9:0][31:0] sc;
      int               gapped;
      int               hold;
      int               cls;
      logic [31:0]      score;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input int gap);
      int n;
      repeat (gap) clk1();
      s_valid = 1'b1;
      s_data  = v;
      n = 0;
      while (!s_ready && n < 100) begin
         clk1();
         n++;
      end
      if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
      clk1();
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      clk1();
      start = 1'b0;
   endtask

   // Called right after the last score's edge: checks 1-cycle latency, hold, handshake.
   task automatic get_result(input string tag, input int hold, input int cls, input logic [31:0] sc);
      logic bad;
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_res_class"}, 32'(res_class), 32'(cls));
      chk({tag, "_res_score"}, res_score, sc);
      bad = 1'b0;
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         clk1();
         if (res_valid !== 1'b1 || res_class !== 4'(cls) || res_score !== sc || s_ready !== 1'b0)
            bad = 1'b1;
      end
      if (hold > 0) chk({tag, "_hold_stable_bad"}, 32'(bad), 32'd0);
      res_ready = 1'b1;
      clk1();
      res_ready = 1'b0;
      chk({tag, "_valid_after_hs"}, 32'(res_valid), 32'd0);
      chk({tag, "_busy_after_hs"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   basic[10] = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 6};
      logic bad;

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; rd_idx = '0; res_ready = 1'b0;
      start_a = 1'b0; s_valid_a = 1'b0; s_data_a = '0; rd_idx_a = '0; res_ready_a = 1'b0;
      start_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; rd_idx_b = '0; res_ready_b = 1'b0;

      for (int i = 0; i < 10; i++) begin
         vecs[0].sc[i] = 32'(basic[i]);
         vecs[1].sc[i] = (i == 4 || i == 7) ? -32'sd1 : -32'sd8;
         vecs[2].sc[i] = 32'd9;
         vecs[3].sc[i] = 32'(basic[i]);
         vecs[4].sc[i] = -32'sd5 - 32'(i);
      end
      vecs[4].sc[9] = 32'h7FFF_FFFF;
      vecs[0].gapped = 0; vecs[0].hold = 0;  vecs[0].cls = 2; vecs[0].score = 32'd12;
      vecs[1].gapped = 0; vecs[1].hold = 0;  vecs[1].cls = 4; vecs[1].score = 32'hFFFF_FFFF;
      vecs[2].gapped = 0; vecs[2].hold = 0;  vecs[2].cls = 0; vecs[2].score = 32'd9;
      vecs[3].gapped = 1; vecs[3].hold = 20; vecs[3].cls = 2; vecs[3].score = 32'd12;
      vecs[4].gapped = 0; vecs[4].hold = 3;  vecs[4].cls = 9; vecs[4].score = 32'h7FFF_FFFF;

      repeat (3) clk1();
      rst = 1'b0;

      // reset state
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_class", 32'(res_class), 32'd0);
      chk("rst_res_score", res_score, 32'd0);
      bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         clk1();
         if (rd_data !== 32'd0) bad = 1'b1;
      end
      chk("rst_bank_nonzero", 32'(bad), 32'd0);

      // table-driven vectors
      for (int k = 0; k < 5; k++) begin
         pulse_start();
         chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
         chk($sformatf("v%0d_s_ready", k), 32'(s_ready), 32'd1);
         for (int i = 0; i < 10; i++)
            send(vecs[k].sc[i], vecs[k].gapped != 0 ? int'($urandom_range(0, 3)) : 0);
         get_result($sformatf("v%0d", k), vecs[k].hold, vecs[k].cls, vecs[k].score);
         for (int i = 0; i < 10; i++) begin
            rd_idx = 4'(i);
            clk1();
            chk($sformatf("v%0d_rd%0d", k, i), rd_data, vecs[k].sc[i]);
         end
         rd_idx = 4'd12;
         clk1();
         chk($sformatf("v%0d_rd_oor", k), rd_data, 32'd0);
      end

      // restart mid-collection; score presented with start must be dropped
      pulse_start();
      send(32'd500, 0); send(32'd400, 0); send(32'd300, 0); send(32'd200, 0);
      start = 1'b1; s_valid = 1'b1; s_data = 32'd1000;
      clk1();
      start = 1'b0; s_valid = 1'b0;
      chk("rs_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 9; i++) send(32'(i * 10), 0);
      send(32'd100, 0);
      chk("rs_res_valid", 32'(res_valid), 32'd1);
      chk("rs_res_class", 32'(res_class), 32'd9);
      chk("rs_res_score", res_score, 32'd100);
      // start in DONE ignored, also in the handshake cycle
      start = 1'b1;
      clk1();
      chk("rs_done_start_valid", 32'(res_valid), 32'd1);
      chk("rs_done_start_class", 32'(res_class), 32'd9);
      res_ready = 1'b1;
      clk1();
      start = 1'b0; res_ready = 1'b0;
      chk("rs_hs_busy", 32'(busy), 32'd0);
      chk("rs_hs_valid", 32'(res_valid), 32'd0);
      rd_idx = 4'd0;
      clk1();
      chk("rs_rd0", rd_data, 32'd0);
      rd_idx = 4'd3;
      clk1();
      chk("rs_rd3", rd_data, 32'd30);

      // reset after 6 scores
      pulse_start();
      for (int i = 0; i < 6; i++) send(32'(50 + i), 0);
      rst = 1'b1;
      clk1();
      rst = 1'b0;
      chk("mr_s_ready", 32'(s_ready), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_res_valid", 32'(res_valid), 32'd0);
      chk("mr_res_class", 32'(res_class), 32'd0);
      chk("mr_res_score", res_score, 32'd0);
      chk("mr_rd_data", rd_data, 32'd0);
      rd_idx = 4'd2;
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         clk1();
         if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("mr_idle_bad", 32'(bad), 32'd0);
      chk("mr_bank_cleared", rd_data, 32'd0);

      // NUM_CLASSES = 2: max at last index, then a tie
      start_a = 1'b1; clk1(); start_a = 1'b0;
      chk("n2_s_ready", 32'(s_ready_a), 32'd1);
      s_valid_a = 1'b1; s_data_a = 16'hFFFB; clk1();
      s_data_a = 16'd3; clk1();
      s_valid_a = 1'b0;
      chk("n2_res_valid", 32'(res_valid_a), 32'd1);
      chk("n2_res_class", 32'(res_class_a), 32'd1);
      chk("n2_res_score", 32'(res_score_a), 32'h0003);
      res_ready_a = 1'b1; clk1(); res_ready_a = 1'b0;
      chk("n2_busy", 32'(busy_a), 32'd0);
      rd_idx_a = 1'b0; clk1();
      chk("n2_rd0", 32'(rd_data_a), 32'h0000_FFFB);
      start_a = 1'b1; clk1(); start_a = 1'b0;
      s_valid_a = 1'b1; s_data_a = 16'd4; clk1();
      clk1();
      s_valid_a = 1'b0;
      chk("n2_tie_class", 32'(res_class_a), 32'd0);
      res_ready_a = 1'b1; clk1(); res_ready_a = 1'b0;

      // NUM_CLASSES = 256: scores i-100, max 155 at index 255
      start_b = 1'b1; clk1(); start_b = 1'b0;
      chk("n256_s_ready", 32'(s_ready_b), 32'd1);
      for (int i = 0; i < 256; i++) begin
         s_valid_b = 1'b1;
         s_data_b  = 16'(i - 100);
         clk1();
      end
      s_valid_b = 1'b0;
      chk("n256_res_valid", 32'(res_valid_b), 32'd1);
      chk("n256_res_class", 32'(res_class_b), 32'd255);
      chk("n256_res_score", 32'(res_score_b), 32'd155);
      res_ready_b = 1'b1; clk1(); res_ready_b = 1'b0;
      chk("n256_busy", 32'(busy_b), 32'd0);
      rd_idx_b = 8'd255; clk1();
      chk("n256_rd255", 32'(rd_data_b), 32'd155);
      rd_idx_b = 8'd0; clk1();
      chk("n256_rd0", 32'(rd_data_b), 32'h0000_FF9C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cnn_result_argmax.md
Name: cnn_result_argmax

Overview:
- Parametrised successor to the fixed ten-score result port of the CNN accelerator.
- Collects NUM_CLASSES signed class scores streamed from the CNN core, one per cycle, over a valid/ready handshake, and stores them in a register bank readable by index.
- Computes the running argmax while the scores arrive, then presents the winning class and its score over a valid/ready result handshake.
- Sits between the CNN core output stage and the AXI-lite/host read-out logic.

Parameters:
- DATA_WIDTH, 32, width of one class score (signed two's complement).
- NUM_CLASSES, 10, number of scores per inference; legal range 2..256.
- IDX_WIDTH (localparam), $clog2(NUM_CLASSES), width of the class index.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new inference collection.
- s_valid  in  1  score on s_data is valid.
- s_data  in  DATA_WIDTH  signed class score, in class order 0..NUM_CLASSES-1.
- s_ready  out  1  block accepts a score this cycle.
- rd_idx  in  IDX_WIDTH  bank read index.
- rd_data  out  DATA_WIDTH  registered bank read data.
- res_valid  out  1  result is available.
- res_ready  in  1  consumer accepts the result.
- res_class  out  IDX_WIDTH  index of the maximum score.
- res_score  out  DATA_WIDTH  value of the maximum score.
- busy  out  1  high in COLLECT or DONE.

Behaviour:
- Clocking and reset:
  - Everything is synchronous to clk.
  - On rst: state is IDLE; count, bank entries, max register, res_class, res_score and rd_data are 0; s_ready, res_valid and busy are 0.
  - rst wins over every other input in the same cycle.
  - rst mid-collection discards all partial data.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - s_ready = 0, res_valid = 0.
  - start -> COLLECT; count cleared to 0.
- COLLECT:
  - s_ready = 1.
  - A score is accepted when s_valid & s_ready. Accepted data is written to bank[count] and count increments.
  - The first accepted score (count == 0) loads max = s_data, idx = 0 unconditionally.
  - Each later score replaces max/idx only if it is strictly greater (signed compare). Ties therefore keep the lowest index.
  - When the score accepted has count == NUM_CLASSES-1: transition to DONE. res_class/res_score are loaded from the final max/idx, including that last score.
  - start in COLLECT restarts: count = 0, and a score presented in the same cycle is ignored. Bank contents are not cleared but will be overwritten.
- DONE:
  - s_ready = 0; res_valid = 1, held with res_class/res_score stable until res_valid & res_ready, then -> IDLE.
  - start in DONE is ignored, including in the handshake cycle.
- busy = (state != IDLE).
- Latency: last score accepted at edge t -> res_valid = 1 after edge t, i.e. 1 cycle.
- Bank read:
  - rd_data <= bank[rd_idx] every cycle, 1-cycle latency, in all states.
  - rd_idx >= NUM_CLASSES returns 0.
  - A read of an index written in the same cycle returns the old value.
- Bank contents persist after DONE until overwritten by the next collection.
- Arithmetic: signed comparison only, no overflow possible; count is IDX_WIDTH+1 bits wide.

Decomposition:
- Package cnn_pkg holds:
  - the state enum typedef (IDLE, COLLECT, DONE);
  - the default CNN_DATA_WIDTH = 32 and CNN_NUM_CLASSES = 10 constants.
- One natural sub-module, cnn_score_bank: NUM_CLASSES x DATA_WIDTH register file with synchronous reset, one write port and one registered read port.
- The FSM and argmax compare live in the top.

Test Plan:
- Reset then idle: after rst, s_ready = 0, res_valid = 0, busy = 0, rd_data = 0 for all indices.
- Basic argmax: start; stream scores 5, -3, 12, 7, 0, 1, 2, 3, 4, 6 back-to-back -> res_valid 1 cycle after the last score, res_class = 2, res_score = 12; rd_idx = 3 returns 7.
- Tie and negatives: scores all -8 except index 4 = -1 and index 7 = -1 -> res_class = 4, res_score = -1; all scores equal 9 -> res_class = 0.
- Backpressure: s_valid gapped randomly and res_ready held low 20 cycles -> results identical to the back-to-back case; res_class/res_score stable while res_ready is low; s_ready = 0 throughout DONE.
- Restart and reset mid-run: start after 4 scores, then 10 fresh scores with max 100 at index 9 -> res_class = 9, res_score = 100. Separately, assert rst after 6 scores -> IDLE, all outputs 0, no res_valid.
- Parameter sweep: NUM_CLASSES = 2 and 256 with DATA_WIDTH = 16, max at the last index -> res_class = NUM_CLASSES-1; rd_idx out of range returns 0.
